// File: rtl/cfg_param_writer.sv
// Staging-word writer for the acceptance-filter parameter registry: collects eight
// 32-bit words, then presents a frozen 256-bit word with setup/pulse/hold timing.
module cfg_param_writer #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 4
) (
    input  logic         clk,
    input  logic         g_rst,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   wr_be,
    input  logic         commit,
    output logic [255:0] data_out,
    output logic         param_ld,
    output logic         busy,
    output logic         done,
    output logic         commit_err,
    output logic [1:0]   dbg_state
);

    // Handshake: commit is accepted only in IDLE; while busy=1 a commit is dropped
    // and answered with a one-cycle commit_err, and done marks the end of a sequence.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;

    localparam logic [7:0] SETUP_INIT = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC - 1);

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [255:0]   r_data;
    logic           r_ld;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [31:0]    r_stage [8];

    state_t         w_state_nx;
    logic [7:0]     w_cnt_nx;
    logic [255:0]   w_data_nx;
    logic           w_ld_nx;
    logic           w_busy_nx;
    logic           w_done_nx;
    logic           w_err_nx;
    logic [255:0]   w_snapshot;

    always_comb begin
        w_snapshot = '0;
        for (int k = 0; k < 8; k++) begin
            w_snapshot[32*k +: 32] = r_stage[k];
        end
    end

    // Byte-masked staging writes; snapshot reads the pre-write contents.
    always_ff @(posedge clk) begin
        if (g_rst) begin
            for (int k = 0; k < 8; k++) begin
                r_stage[k] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_stage[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_data_nx  = r_data;
        w_ld_nx    = 1'b0;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (commit) begin
                    w_data_nx  = w_snapshot;
                    w_busy_nx  = 1'b1;
                    w_cnt_nx   = SETUP_INIT;
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                w_err_nx = commit;
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else begin
                    w_ld_nx    = 1'b1;
                    w_state_nx = S_PULSE;
                end
            end
            S_PULSE: begin
                w_err_nx   = commit;
                w_cnt_nx   = HOLD_INIT;
                w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                w_err_nx = commit;
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else begin
                    w_busy_nx  = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ld    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_data  <= w_data_nx;
            r_ld    <= w_ld_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    assign data_out   = r_data;
    assign param_ld   = r_ld;
    assign busy       = r_busy;
    assign done       = r_done;
    assign commit_err = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cfg_param_writer.sv
// Directed bench for cfg_param_writer: reset, field placement, byte enables,
// busy rejection, write/commit collision, held commit and mid-sequence reset.
module tb_cfg_param_writer;

    logic         clk = 1'b0;
    logic         g_rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic         commit;
    logic [255:0] data_out;
    logic         param_ld;
    logic         busy;
    logic         done;
    logic         commit_err;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    cfg_param_writer #(.SETUP_CYC(2), .HOLD_CYC(4)) dut (
        .clk        (clk),
        .g_rst      (g_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .commit     (commit),
        .data_out   (data_out),
        .param_ld   (param_ld),
        .busy       (busy),
        .done       (done),
        .commit_err (commit_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
        tick();
        wr_en   = 1'b0;
        wr_be   = 4'h0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        g_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; commit = 1'b0;
        tick();
        tick();
        g_rst = 1'b0;
        n_tests++; if (data_out !== 256'b0) begin n_fail++; $display("FAIL rst_data_out got %h exp 0", data_out); end
        n_tests++; if (param_ld !== 1'b0) begin n_fail++; $display("FAIL rst_param_ld got %b exp 0", param_ld); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_tests++; if (commit_err !== 1'b0) begin n_fail++; $display("FAIL rst_commit_err got %b exp 0", commit_err); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
        // Synchronous reset: asserting g_rst mid-cycle must not change outputs before the edge.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
        g_rst = 1'b1;
        #2;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_sync_busy got %b exp 1", busy); end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_edge_busy got %b exp 0", busy); end
        g_rst = 1'b0;
        tick();
    endtask

    task automatic test_field_placement();
        logic [255:0] exp_word;
        logic [10:0]  code_param;
        logic [10:0]  mask_param;
        logic [1:0]   sjw;
        exp_word = {32'hABC00000, 32'h0, 32'h000007FF, 32'hC0000000, 128'h0};
        write_word(3'd7, 32'hABC00000, 4'hF);
        write_word(3'd5, 32'h000007FF, 4'hF);
        write_word(3'd4, 32'hC0000000, 4'hF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        code_param = data_out[255:245];
        mask_param = data_out[170:160];
        sjw        = data_out[159:158];
        n_tests++; if (data_out !== exp_word) begin n_fail++; $display("FAIL field_word got %h exp %h", data_out, exp_word); end
        n_tests++; if (code_param !== 11'h55E) begin n_fail++; $display("FAIL field_code got %h exp 55e", code_param); end
        n_tests++; if (mask_param !== 11'h7FF) begin n_fail++; $display("FAIL field_mask got %h exp 7ff", mask_param); end
        n_tests++; if (sjw !== 2'd3) begin n_fail++; $display("FAIL field_sjw got %0d exp 3", sjw); end
        n_tests++; if (busy !== 1'b1 || param_ld !== 1'b0) begin n_fail++; $display("FAIL field_e0 busy %b ld %b exp 1 0", busy, param_ld); end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_tests++; if (param_ld !== (e == 2)) begin n_fail++; $display("FAIL field_ld_e%0d got %b exp %b", e, param_ld, (e == 2)); end
            n_tests++; if (busy !== (e < 7)) begin n_fail++; $display("FAIL field_busy_e%0d got %b exp %b", e, busy, (e < 7)); end
            n_tests++; if (done !== (e == 7)) begin n_fail++; $display("FAIL field_done_e%0d got %b exp %b", e, done, (e == 7)); end
            n_tests++; if (data_out !== exp_word) begin n_fail++; $display("FAIL field_hold_e%0d got %h", e, data_out); end
        end
    endtask

    task automatic test_byte_enables();
        bit to;
        write_word(3'd0, 32'h11223344, 4'hF);
        write_word(3'd0, 32'hAABBCCDD, 4'b0101);
        write_word(3'd0, 32'hFFFFFFFF, 4'b0000);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++; if (data_out[31:0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_word got %h exp 11bb33dd", data_out[31:0]); end
        wait_done(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL be_done_timeout got %b exp 0", to); end
    endtask

    task automatic test_busy_reject();
        int ld_cnt;
        bit to;
        ld_cnt = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (e == 3) commit = 1'b1;
            if (e == 4) begin
                wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
            end
            tick();
            commit = 1'b0;
            wr_en  = 1'b0;
            if (param_ld === 1'b1) ld_cnt++;
            n_tests++; if (commit_err !== (e == 3)) begin n_fail++; $display("FAIL rej_err_e%0d got %b exp %b", e, commit_err, (e == 3)); end
            n_tests++; if (data_out[255:224] !== 32'hABC00000) begin n_fail++; $display("FAIL rej_frozen_e%0d got %h exp abc00000", e, data_out[255:224]); end
        end
        n_tests++; if (ld_cnt !== 1) begin n_fail++; $display("FAIL rej_ld_count got %0d exp 1", ld_cnt); end
        tick();
        n_tests++; if (data_out[255:224] !== 32'hABC00000) begin n_fail++; $display("FAIL rej_idle_frozen got %h exp abc00000", data_out[255:224]); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++; if (data_out[255:224] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rej_next got %h exp ffffffff", data_out[255:224]); end
        wait_done(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rej_done_timeout got %b exp 0", to); end
    endtask

    task automatic test_simul_write_commit();
        bit to;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h5A5A5A5A; wr_be = 4'hF;
        commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        n_tests++; if (data_out[63:32] !== 32'h0) begin n_fail++; $display("FAIL simul_first got %h exp 0", data_out[63:32]); end
        wait_done(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL simul_timeout got %b exp 0", to); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++; if (data_out[63:32] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL simul_second got %h exp 5a5a5a5a", data_out[63:32]); end
        wait_done(to);
    endtask

    task automatic test_back_to_back();
        bit to;
        commit = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b1 || commit_err !== 1'b0) begin n_fail++; $display("FAIL b2b_e0 busy %b err %b exp 1 0", busy, commit_err); end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_tests++; if (commit_err !== (e <= 7)) begin n_fail++; $display("FAIL b2b_err_e%0d got %b exp %b", e, commit_err, (e <= 7)); end
            n_tests++; if (done !== (e == 7)) begin n_fail++; $display("FAIL b2b_done_e%0d got %b exp %b", e, done, (e == 7)); end
        end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got %b exp 1", busy); end
        commit = 1'b0;
        n_tests++; if (data_out[255:224] !== 32'hFFFFFFFF || data_out[63:32] !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL b2b_word got %h / %h", data_out[255:224], data_out[63:32]);
        end
        wait_done(to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got %b exp 0", to); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        logic [255:0] exp_word;
        done_cnt = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        g_rst = 1'b1;
        tick();
        n_tests++; if (param_ld !== 1'b0) begin n_fail++; $display("FAIL mid_ld got %b exp 0", param_ld); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_tests++; if (data_out !== 256'b0) begin n_fail++; $display("FAIL mid_data got %h exp 0", data_out); end
        g_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || param_ld === 1'b1) done_cnt++;
        end
        n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d exp 0", done_cnt); end
        write_word(3'd3, 32'h12345678, 4'hF);
        exp_word = {128'h0, 32'h12345678, 96'h0};
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_tests++; if (data_out !== exp_word) begin n_fail++; $display("FAIL mid_new_word got %h exp %h", data_out, exp_word); end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_tests++; if (param_ld !== (e == 2)) begin n_fail++; $display("FAIL mid_ld_e%0d got %b exp %b", e, param_ld, (e == 2)); end
            n_tests++; if (done !== (e == 7)) begin n_fail++; $display("FAIL mid_done_e%0d got %b exp %b", e, done, (e == 7)); end
        end
    endtask

    initial begin
        test_reset();
        test_field_placement();
        test_byte_enables();
        test_busy_reject();
        test_simul_write_commit();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_param_writer.md
Name: cfg_param_writer

Overview:
- Host-side writer for the 256-bit parameter word consumed by the acceptance-filter parameter registry. That registry extracts code_param [255:245], mask_param [170:160] and sjw [159:158].
- The host writes eight 32-bit staging words, then issues commit.
- The block then presents a stable 256-bit data_out and pulses param_ld. It holds data_out long enough for the registry's two-stage input synchronisers and its load state machine to capture it.

Parameters:
- SETUP_CYC, 2, cycles data_out is stable before param_ld rises; legal range 1..255.
- HOLD_CYC, 4, cycles after the param_ld pulse during which busy stays high and data_out is frozen; legal range 1..255.

Ports:
- clk  in  1  clock.
- g_rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  staging-word write strobe.
- wr_addr  in  3  staging word index; word k maps to data bits [32k+31:32k].
- wr_data  in  32  write data.
- wr_be  in  4  byte enables; bit i enables wr_data[8i+7:8i].
- commit  in  1  request to load the staged word into the registry.
- data_out  out  256  parameter word to the registry's data_in.
- param_ld  out  1  one-cycle load pulse to the registry.
- busy  out  1  commit sequence in progress.
- done  out  1  one-cycle pulse when a commit sequence ends.
- commit_err  out  1  one-cycle pulse when a commit is rejected.

Behaviour:
- Reset: applied on a clk edge with g_rst=1. All outputs are 0, staging words are 0, state=IDLE, counter=0. Reset mid-sequence aborts immediately; param_ld and busy are 0 after that edge.
- All outputs are registered.
- Staging writes:
  - Accepted on any edge with wr_en=1, in any state.
  - Only enabled bytes of stage[wr_addr] are updated; wr_be=0 leaves the word unchanged.
  - Writes never touch data_out directly.
- FSM states: IDLE, SETUP, PULSE, HOLD. Counter is 8 bits.
- IDLE:
  - commit=1 at an edge: data_out<=concatenation of stage[7..0]; busy<=1; counter<=SETUP_CYC-1; go to SETUP.
  - The snapshot uses staging contents before any same-edge write, so a write coincident with commit is not included in this load.
- SETUP:
  - counter!=0: decrement.
  - counter==0: param_ld<=1; go to PULSE.
- PULSE:
  - param_ld<=0; counter<=HOLD_CYC-1; go to HOLD.
  - param_ld is exactly one cycle wide.
- HOLD:
  - counter!=0: decrement.
  - counter==0: busy<=0; done<=1 for one cycle; go to IDLE.
- Timing with defaults, counting edges from the commit edge E0:
  - param_ld is high between E2 and E3.
  - busy is high from E0 to E7.
  - done is high between E7 and E8.
  - Total sequence is SETUP_CYC+HOLD_CYC+2 edges.
- data_out is frozen from the commit edge until the next accepted commit. It is never changed outside the IDLE commit transition.
- commit=1 in SETUP, PULSE or HOLD: ignored, and commit_err<=1 for one cycle. State, counter, data_out and param_ld are unaffected.
- commit held high continuously:
  - accepted at the first IDLE edge;
  - commit_err pulses on every busy edge;
  - a new sequence starts at the edge after the done transition, when the FSM is back in IDLE.
- The done pulse and a new commit acceptance may coincide only when the new commit is sampled in IDLE, i.e. one edge after the done transition.
- Back-to-back commits with unchanged staging are legal and re-present the same word.

Test Plan:
- Reset state: assert g_rst for 2 cycles, then release. Required: data_out=0, param_ld=0, busy=0, done=0, commit_err=0; reset behaves synchronously (no output change without a clk edge).
- Field placement: write stage7=0xABC00000, stage5=0x000007FF, stage4=0xC0000000 (wr_be=4'hF), then commit. Required:
  - data_out[255:245]=0x55E, data_out[170:160]=0x7FF, data_out[159:158]=2'b11;
  - param_ld high exactly one cycle, at E2;
  - busy high E0..E7, done pulse at E7;
  - a connected registry outputs code_param=0x55E, mask_param=0x7FF, sjw=3.
- Byte enables: stage0=0x11223344, then write 0xAABBCCDD with wr_be=4'b0101, then commit. Required: data_out[31:0]=0x11BB33DD.
- Busy rejection: commit at E0, second commit at E3, staging write of stage7=0xFFFFFFFF at E4. Required:
  - commit_err pulses once, at E3;
  - single param_ld pulse;
  - data_out[255:224] unchanged until the next commit;
  - next commit presents 0xFFFFFFFF in data_out[255:224].
- Simultaneous write and commit: stage1=0x0 with wr_en=1, wr_addr=1, wr_data=0x5A5A5A5A and commit=1 at the same edge. Required: data_out[63:32]=0x0; a following commit shows 0x5A5A5A5A.
- Reset mid-operation: g_rst=1 at E2, while param_ld is being set. Required: after that edge param_ld=0, busy=0, data_out=0, no done pulse; a subsequent commit runs a normal full sequence.
